// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between NP requesters.
// Write bursts hold the grant until their last beat is accepted; reads are
// released immediately and their return beats are routed back through an
// in-order FIFO of {port id, beat count}.
// Build option: define SDRAM_ARB_FIXED_PRIO_EN to grant the lowest-index
// eligible port instead of using the round-robin pointer.
//
// state | meaning
// IDLE  | free arbitration, any eligible port may be granted
// LOCK  | write burst in progress, grant held on lock_q until remain_q hits 0
module sdram_arbiter #(
    parameter int DW   = 16,
    parameter int AW   = 24,
    parameter int NP   = 2,
    parameter int OUTQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NP-1:0]   m_read,
    input  logic [NP-1:0]   m_write,
    input  logic [NP-1:0]   m_burst,
    output logic [NP-1:0]   m_ready,
    output logic [NP-1:0]   m_rvalid,
    input  logic [NP*AW-1:0] m_addr,
    input  logic [NP*3-1:0] m_burst_len,
    input  logic [NP*DW-1:0] m_wdata,
    input  logic [NP*2-1:0] m_byteenable,
    output logic [DW-1:0]   m_rdata,
    output logic            bus_read,
    output logic            bus_write,
    output logic [AW-1:0]   bus_addr,
    output logic            bus_burst,
    output logic [2:0]      bus_burst_len,
    output logic [DW-1:0]   bus_wdata,
    output logic [1:0]      bus_byteenable,
    input  logic            bus_ready,
    input  logic            bus_rvalid,
    input  logic [DW-1:0]   bus_rdata,
    output logic            rsp_err
);
    localparam int IDW = (NP > 1) ? $clog2(NP) : 1;
    localparam int QW  = (OUTQ > 1) ? $clog2(OUTQ) : 1;
    localparam int CW  = $clog2(OUTQ + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state_q;
    logic [IDW-1:0] lock_q;
    logic [3:0]     remain_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
`endif

    logic [IDW-1:0] fq_id_q [OUTQ];
    logic [3:0]     fq_bc_q [OUTQ];
    logic [QW-1:0]  wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CW-1:0]  occ_q;
    logic [3:0]     beat_q;
    logic           rsp_err_q;

    logic           fifo_full, fifo_empty;
    logic [NP-1:0]  elig;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_idx;
    logic           accept;
    logic [3:0]     beats;
    logic           push, pop, rv_hit, last_beat;
    logic [IDW-1:0] head_id;

    assign fifo_full  = (occ_q == CW'(OUTQ));
    assign fifo_empty = (occ_q == '0);

    // A read cannot be taken while the routing FIFO is full; writes still can.
    assign elig = (m_read | m_write) & ~(m_read & {NP{fifo_full}});

    // Select the granted port: the locked port in LOCK, else first eligible.
    always_comb begin : grant_sel
        int c;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        c       = 0;
        if (state_q == LOCK) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_q;
        end else begin
            for (int i = 0; i < NP; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                c = i;
`else
                c = int'(rr_ptr_q) + i;
                if (c >= NP) c = c - NP;
`endif
                if (!gnt_vld && elig[c]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IDW'(c);
                end
            end
        end
    end

    // Zero-latency forwarding; read wins when a port raises both read and write.
    assign bus_read       = rst_n & gnt_vld & m_read[gnt_idx];
    assign bus_write      = rst_n & gnt_vld & m_write[gnt_idx] & ~m_read[gnt_idx];
    assign bus_addr       = gnt_vld ? m_addr[int'(gnt_idx)*AW +: AW] : '0;
    assign bus_burst      = gnt_vld & m_burst[gnt_idx];
    assign bus_burst_len  = gnt_vld ? m_burst_len[int'(gnt_idx)*3 +: 3] : '0;
    assign bus_wdata      = gnt_vld ? m_wdata[int'(gnt_idx)*DW +: DW] : '0;
    assign bus_byteenable = gnt_vld ? m_byteenable[int'(gnt_idx)*2 +: 2] : '0;
    assign m_rdata        = bus_rdata;
    assign rsp_err        = rsp_err_q;

    assign accept = (bus_read | bus_write) & bus_ready;
    assign beats  = bus_burst ? ({1'b0, bus_burst_len} + 4'd1) : 4'd1;

    // Only the granted port sees the controller's ready.
    always_comb begin
        m_ready = '0;
        if (rst_n && gnt_vld) m_ready[gnt_idx] = bus_ready;
    end

    assign head_id   = fq_id_q[rd_ptr_q];
    assign rv_hit    = bus_rvalid & ~fifo_empty;
    assign last_beat = ((beat_q + 4'd1) == fq_bc_q[rd_ptr_q]);
    assign push      = accept & bus_read & ~fifo_full;
    assign pop       = rv_hit & last_beat;
    assign wr_ptr_d  = (wr_ptr_q == QW'(OUTQ - 1)) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_d  = (rd_ptr_q == QW'(OUTQ - 1)) ? '0 : rd_ptr_q + 1'b1;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    assign rr_ptr_d  = (int'(gnt_idx) == NP - 1) ? '0 : gnt_idx + 1'b1;
`endif

    // Return beats go to the port at the head of the routing FIFO.
    always_comb begin
        m_rvalid = '0;
        if (rst_n && rv_hit) m_rvalid[head_id] = 1'b1;
    end

    // Arbitration FSM: lock on multi-beat writes, advance pointer on first beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lock_q   <= '0;
            remain_q <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                        rr_ptr_q <= rr_ptr_d;
`endif
                        if (bus_write && beats > 4'd1) begin
                            state_q  <= LOCK;
                            lock_q   <= gnt_idx;
                            remain_q <= beats - 4'd1;
                        end
                    end
                end
                LOCK: begin
                    if (accept) begin
                        remain_q <= remain_q - 4'd1;
                        if (remain_q == 4'd1) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read-routing FIFO, per-head beat counter and sticky stray-rvalid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            beat_q    <= '0;
            rsp_err_q <= 1'b0;
            for (int i = 0; i < OUTQ; i++) begin
                fq_id_q[i] <= '0;
                fq_bc_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fq_id_q[wr_ptr_q] <= gnt_idx;
                fq_bc_q[wr_ptr_q] <= beats;
                wr_ptr_q          <= wr_ptr_d;
            end
            if (rv_hit) begin
                if (last_beat) begin
                    beat_q   <= '0;
                    rd_ptr_q <= rd_ptr_d;
                end else begin
                    beat_q <= beat_q + 4'd1;
                end
            end
            if (push && !pop)      occ_q <= occ_q + 1'b1;
            else if (pop && !push) occ_q <= occ_q - 1'b1;
            if (bus_rvalid && fifo_empty) rsp_err_q <= 1'b1;
        end
    end
endmodule
